vec_arith_pipe: RTL
===================

VEC_ARITH_PIPE -- requirements
Module: vec_arith_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, element width in bits.
REQ-002 The block SHALL have parameter LENGTH, default 1024, elements per vector.
REQ-003 The block SHALL have parameter LANES, default 8, elements processed per beat; LENGTH SHALL be an integer multiple of LANES (elaboration-time check).
REQ-004 The block SHALL have parameter SATURATE, default 0, where 1 selects saturating sum.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to begin an operation.
REQ-008 op  input  8  operation code, sampled only on accepted start.
REQ-009 out_a  input  LENGTH x WIDTH  operand vector A, held stable by upstream while busy=1.
REQ-010 out_b  input  LENGTH x WIDTH  operand vector B, same stability rule.
REQ-011 busy  output  1  high from the cycle after accepted start until calc_ready deasserts.
REQ-012 calc_ready  output  1  one-cycle pulse: aux_result complete and valid.
REQ-013 aux_result  output  LENGTH x WIDTH  registered result vector.

Function
REQ-014 Supported ops: OP_SUM_VEC, OP_AVG_VEC, OP_ABSDIFF_VEC; any other code SHALL be ignored with the block staying IDLE.
REQ-015 Sum: (a+b) computed at WIDTH+1 bits; SATURATE=0 keeps low WIDTH bits; SATURATE=1 clamps to 2^WIDTH-1.
REQ-016 Avg: bits [WIDTH:1] of the WIDTH+1-bit sum (floor division by 2, no overflow).
REQ-017 AbsDiff: |a-b| in WIDTH bits, unsigned operands.
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; encoding from the shared package.
REQ-019 IDLE -> RUN on start=1 with a valid op; op latched; beat index cleared to 0.
REQ-020 RUN: each cycle the lane group at index*LANES..index*LANES+LANES-1 SHALL be computed and registered in stage 1; the index increments; after beat BEATS-1 (BEATS=LENGTH/LANES) -> DRAIN.
REQ-021 Stage 2 SHALL write the stage-1 lane results into aux_result at the same group position one cycle after stage 1.
REQ-022 DRAIN -> DONE when the final beat is written; DONE asserts calc_ready for exactly one cycle, then -> IDLE.
REQ-023 Latency: with the start accepted at edge E0, calc_ready SHALL be high during the cycle after edge E(BEATS+2), i.e. BEATS+3 edges total.
REQ-024 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-025 aux_result elements not yet rewritten SHALL keep their previous value during an operation.
REQ-026 The op-code change while busy SHALL have no effect on the running operation.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, clear the beat index, busy=0, calc_ready=0, all aux_result elements=0 and pipeline registers=0.
REQ-028 Reset mid-operation SHALL abort with no calc_ready pulse; the next start after release SHALL run a full operation.

Structure
REQ-029 Package vec_ops_pkg SHALL hold the op codes (OP_SUM_VEC, OP_AVG_VEC, OP_ABSDIFF_VEC) and the FSM state enum.
REQ-030 Sub-module vec_lane_alu (combinational, one element, WIDTH/SATURATE parameters) SHALL be instantiated LANES times.

Verification (LENGTH=16, LANES=4, WIDTH=8, BEATS=4)
REQ-031 SUM, a[i]=i, b[i]=2i -> aux_result[i]=3i; calc_ready single pulse during the cycle after edge E6; busy high from after E0 until the pulse ends.
REQ-032 SUM, a=200, b=100, SATURATE=0 -> 44; SATURATE=1 -> 255.
REQ-033 AVG, a=255, b=254 -> 254; AVG, a=3, b=0 -> 1.
REQ-034 ABSDIFF, a=10, b=250 -> 240; a=250, b=10 -> 240.
REQ-035 start with op=8'hFF -> busy stays 0, no calc_ready; second start during RUN ignored (one pulse only).
REQ-036 reset asserted after E2 of a SUM run -> aux_result all 0, no pulse; a fresh start completes normally.

Source files
------------

// File: rtl/vec_ops_pkg.sv
// vec_ops_pkg: shared op codes and FSM state encoding for vec_arith_pipe.
package vec_ops_pkg;

    localparam logic [7:0] OP_SUM_VEC     = 8'h01;
    localparam logic [7:0] OP_AVG_VEC     = 8'h02;
    localparam logic [7:0] OP_ABSDIFF_VEC = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True for op codes the pipeline can execute; anything else keeps it idle.
    function automatic logic op_is_valid(input logic [7:0] op);
        return (op == OP_SUM_VEC) || (op == OP_AVG_VEC) || (op == OP_ABSDIFF_VEC);
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational single-element arithmetic unit.
// Ports:
//   op    - operation code (vec_ops_pkg op codes)
//   a, b  - unsigned WIDTH-bit operands
//   res_c - combinational WIDTH-bit result (0 for unknown op codes)
module vec_lane_alu
    import vec_ops_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_c
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        res_c = '0;
        case (op)
            OP_SUM_VEC: begin
                if ((SATURATE != 0) && sum[WIDTH]) begin
                    res_c = '1;
                end else begin
                    res_c = sum[WIDTH-1:0];
                end
            end
            // Floor average: drop the LSB of the carry-extended sum.
            OP_AVG_VEC:     res_c = sum[WIDTH:1];
            OP_ABSDIFF_VEC: res_c = (a >= b) ? (a - b) : (b - a);
            default:        res_c = '0;
        endcase
    end

endmodule

// File: rtl/vec_arith_pipe.sv
// vec_arith_pipe: lane-parallel element-wise vector arithmetic with a
// two-stage pipeline (stage 1 computes LANES elements per beat, stage 2
// writes them back into the registered result vector).
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   start, op    - operation request; op sampled only when start is accepted
//   out_a, out_b - LENGTH x WIDTH operand vectors, stable while busy
//   busy         - high from the cycle after an accepted start to the end of calc_ready
//   calc_ready   - one-cycle pulse when aux_result is complete
//   aux_result   - LENGTH x WIDTH registered result vector
module vec_arith_pipe
    import vec_ops_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LENGTH   = 1024,
    parameter int unsigned LANES    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    op,
    input  logic [LENGTH-1:0][WIDTH-1:0]  out_a,
    input  logic [LENGTH-1:0][WIDTH-1:0]  out_b,
    output logic                          busy,
    output logic                          calc_ready,
    output logic [LENGTH-1:0][WIDTH-1:0]  aux_result
);

    localparam int unsigned BEATS = LENGTH / LANES;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((LENGTH % LANES) != 0) begin : g_bad_length
        $error("vec_arith_pipe: LENGTH must be a multiple of LANES");
    end

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [7:0]                    op_q;

    logic [LANES-1:0][WIDTH-1:0]   lane_a;
    logic [LANES-1:0][WIDTH-1:0]   lane_b;
    logic [LANES-1:0][WIDTH-1:0]   lane_res_c;

    logic [LANES-1:0][WIDTH-1:0]   s1_res;
    logic [IDX_W-1:0]              s1_idx;
    logic                          s1_valid;
    logic                          s1_last;
    logic                          wr_last;

    logic                          last_beat_c;

    assign last_beat_c = (idx == IDX_W'(BEATS - 1));

    // Select the operand lane group addressed by the current beat index.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int bt = 0; bt < int'(BEATS); bt++) begin
            if (idx == IDX_W'(bt)) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    lane_a[l] = out_a[bt * int'(LANES) + l];
                    lane_b[l] = out_b[bt * int'(LANES) + l];
                end
            end
        end
    end

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        vec_lane_alu #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_alu (
            .op    (op_q),
            .a     (lane_a[l]),
            .b     (lane_b[l]),
            .res_c (lane_res_c[l])
        );
    end

    // Control FSM; DRAIN waits for the write-back of the final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            op_q       <= '0;
            busy       <= 1'b0;
            calc_ready <= 1'b0;
        end else begin
            calc_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && op_is_valid(op)) begin
                        state <= ST_RUN;
                        op_q  <= op;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    idx <= idx + 1'b1;
                    if (last_beat_c) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (wr_last) begin
                        state      <= ST_DONE;
                        calc_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 captures lane results; stage 2 writes them to their group slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_res     <= '0;
            s1_idx     <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            wr_last    <= 1'b0;
            aux_result <= '0;
        end else begin
            s1_valid <= (state == ST_RUN);
            s1_last  <= (state == ST_RUN) && last_beat_c;
            s1_idx   <= idx;
            if (state == ST_RUN) begin
                s1_res <= lane_res_c;
            end
            wr_last <= s1_valid && s1_last;
            if (s1_valid) begin
                for (int bt = 0; bt < int'(BEATS); bt++) begin
                    if (s1_idx == IDX_W'(bt)) begin
                        for (int l = 0; l < int'(LANES); l++) begin
                            aux_result[bt * int'(LANES) + l] <= s1_res[l];
                        end
                    end
                end
            end
        end
    end

endmodule
